// File: rtl/coco_kbd_pkg.sv
// Shared types, matrix geometry and the set-2 scancode to CoCo 3 matrix map
// for the keyboard matrix block.
package coco_kbd_pkg;

  localparam int ROWS      = 7;
  localparam int COLS      = 8;
  localparam int SHIFT_ROW = 6;
  localparam int SHIFT_COL = 7;
  localparam int SHIFT_IDX = SHIFT_ROW * COLS + SHIFT_COL;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_APPLY
  } kbd_state_t;

  typedef struct packed {
    logic       press;
    logic       ext;
    logic [7:0] code;
  } kbd_event_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] row;
    logic [2:0] col;
    logic       lsh;
    logic       rsh;
  } kbd_pos_t;

  // Positions are written in octal as row,col so each entry reads like the layout table.
  function automatic kbd_pos_t ps2_to_coco(input logic ext, input logic [7:0] code);
    kbd_pos_t   p;
    logic [5:0] rc;
    p     = '0;
    rc    = '0;
    p.hit = 1'b1;
    if (ext) begin
      case (code)
        8'h75:   rc = 6'o33;
        8'h72:   rc = 6'o34;
        8'h6B:   rc = 6'o35;
        8'h74:   rc = 6'o36;
        8'h5A:   rc = 6'o60;
        8'h6C:   rc = 6'o61;
        default: p.hit = 1'b0;
      endcase
    end else begin
      case (code)
        8'h54: rc = 6'o00;  8'h1C: rc = 6'o01;  8'h32: rc = 6'o02;  8'h21: rc = 6'o03;
        8'h23: rc = 6'o04;  8'h24: rc = 6'o05;  8'h2B: rc = 6'o06;  8'h34: rc = 6'o07;
        8'h33: rc = 6'o10;  8'h43: rc = 6'o11;  8'h3B: rc = 6'o12;  8'h42: rc = 6'o13;
        8'h4B: rc = 6'o14;  8'h3A: rc = 6'o15;  8'h31: rc = 6'o16;  8'h44: rc = 6'o17;
        8'h4D: rc = 6'o20;  8'h15: rc = 6'o21;  8'h2D: rc = 6'o22;  8'h1B: rc = 6'o23;
        8'h2C: rc = 6'o24;  8'h3C: rc = 6'o25;  8'h2A: rc = 6'o26;  8'h1D: rc = 6'o27;
        8'h22: rc = 6'o30;  8'h35: rc = 6'o31;  8'h1A: rc = 6'o32;  8'h66: rc = 6'o35;
        8'h29: rc = 6'o37;
        8'h45: rc = 6'o40;  8'h16: rc = 6'o41;  8'h1E: rc = 6'o42;  8'h26: rc = 6'o43;
        8'h25: rc = 6'o44;  8'h2E: rc = 6'o45;  8'h36: rc = 6'o46;  8'h3D: rc = 6'o47;
        8'h3E: rc = 6'o50;  8'h46: rc = 6'o51;  8'h52: rc = 6'o52;  8'h4C: rc = 6'o53;
        8'h41: rc = 6'o54;  8'h4E: rc = 6'o55;  8'h49: rc = 6'o56;  8'h4A: rc = 6'o57;
        8'h5A: rc = 6'o60;  8'h76: rc = 6'o62;  8'h11: rc = 6'o63;  8'h14: rc = 6'o64;
        8'h05: rc = 6'o65;  8'h06: rc = 6'o66;
        8'h12: begin rc = 6'o67; p.lsh = 1'b1; end
        8'h59: begin rc = 6'o67; p.rsh = 1'b1; end
        default: p.hit = 1'b0;
      endcase
    end
    p.row = rc[5:3];
    p.col = rc[2:0];
    return p;
  endfunction

endpackage

// File: rtl/coco_keymatrix_toggle_sync.sv
// Synchronizes the hps_io event toggle and flags each change as a one-cycle pulse.
// Pulses stay masked after reset until the previous-value register has caught up.
module toggle_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic tog,
  output logic pulse
);

  localparam int AW = $clog2(SYNC_STAGES + 2);
  localparam logic [AW-1:0] ARM_DONE = AW'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [AW-1:0]          arm_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      arm_q  <= '0;
    end else begin
      sync_q <= (sync_q << 1) | SYNC_STAGES'(tog);
      prev_q <= sync_q[SYNC_STAGES-1];
      if (arm_q != ARM_DONE) arm_q <= arm_q + 1'b1;
    end
  end

  assign pulse = (arm_q == ARM_DONE) && (sync_q[SYNC_STAGES-1] != prev_q);

endmodule

// File: rtl/coco_keymatrix.sv
// Decoded PS/2 key events to CoCo 3 7x8 keyboard matrix with registered,
// active-low row returns for the PIA column strobes.
//
// state     | meaning
// ST_IDLE   | waiting for a pending event; moves it into the working register
// ST_LOOKUP | scancode mapped to matrix position
// ST_APPLY  | matrix and shift flags updated, key_valid raised on a change
module coco_keymatrix
  import coco_kbd_pkg::*;
#(
  parameter int SYNC_STAGES       = 2,
  parameter bit AUTOREPEAT_IGNORE = 1'b1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic        clear_all,
  input  logic [7:0]  col_n,
  output logic [6:0]  row_n,
  output logic        key_valid,
  output logic [55:0] matrix
);

  kbd_state_t state_q, state_d;
  kbd_event_t pend_evt_q, evt_q;
  kbd_pos_t   pos_q;
  logic       pend_valid_q;
  logic       evt_pulse;
  logic       lsh_q, rsh_q, lsh_d, rsh_d;
  logic [55:0] mat_d;
  logic [5:0]  idx;
  logic        kv_d;

  toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_sys (clk_sys),
    .reset   (reset),
    .tog     (ps2_key[10]),
    .pulse   (evt_pulse)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (pend_valid_q) state_d = ST_LOOKUP;
      ST_LOOKUP: state_d = ST_APPLY;
      ST_APPLY:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (clear_all) state_d = ST_IDLE;
  end

  // Next matrix contents for the APPLY step; shift bit is always the OR of both flags.
  always_comb begin
    lsh_d = lsh_q;
    rsh_d = rsh_q;
    mat_d = matrix;
    idx   = {pos_q.row, pos_q.col};
    if (pos_q.hit) begin
      if (pos_q.lsh)      lsh_d = evt_q.press;
      else if (pos_q.rsh) rsh_d = evt_q.press;
      else                mat_d[idx] = evt_q.press;
      mat_d[SHIFT_IDX] = lsh_d | rsh_d;
    end
    kv_d = (mat_d != matrix) || (!AUTOREPEAT_IGNORE && pos_q.hit && evt_q.press);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      pend_valid_q <= 1'b0;
      pend_evt_q   <= '0;
      evt_q        <= '0;
      pos_q        <= '0;
      lsh_q        <= 1'b0;
      rsh_q        <= 1'b0;
      matrix       <= '0;
      key_valid    <= 1'b0;
    end else if (clear_all) begin
      pend_valid_q <= 1'b0;
      lsh_q        <= 1'b0;
      rsh_q        <= 1'b0;
      matrix       <= '0;
      key_valid    <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      // A fresh event overwrites anything still pending.
      if (evt_pulse) begin
        pend_valid_q <= 1'b1;
        pend_evt_q   <= ps2_key[9:0];
      end else if (state_q == ST_IDLE && pend_valid_q) begin
        pend_valid_q <= 1'b0;
      end
      if (state_q == ST_IDLE && pend_valid_q) evt_q <= pend_evt_q;
      if (state_q == ST_LOOKUP) pos_q <= ps2_to_coco(evt_q.ext, evt_q.code);
      if (state_q == ST_APPLY) begin
        matrix    <= mat_d;
        lsh_q     <= lsh_d;
        rsh_q     <= rsh_d;
        key_valid <= kv_d;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      row_n <= '1;
    end else begin
      for (int r = 0; r < ROWS; r++)
        row_n[r] <= ~|(matrix[r*COLS +: COLS] & ~col_n);
    end
  end

endmodule
